// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between the EX stage and the dmem req/gnt/rvalid port
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN (misaligned accesses become two bus beats)
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_load_op_i,
    input  logic [2:0]  req_store_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_err_o,
    output logic        stall_o,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ADDR2, S_DATA2, S_DONE} state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            is_store;
    logic [2:0]      op;
    logic [1:0]      off;
    logic [4:0]      rd;

    logic [2:0]  in_op;
    logic [1:0]  in_off;
    logic [3:0]  in_mask;
    logic        in_illegal;
    logic        in_misal;
    logic        wd_expired;
    logic [31:0] lane_single;

    always_comb begin
        in_op   = req_store_i ? req_store_op_i : req_load_op_i;
        in_off  = req_addr_i[1:0];
        case (in_op[1:0])
            2'b00:   in_mask = 4'b0001;
            2'b01:   in_mask = 4'b0011;
            default: in_mask = 4'b1111;
        endcase
        if (req_store_i)
            in_illegal = in_op[2] || (in_op[1:0] == 2'b11);
        else
            in_illegal = (in_op[1:0] == 2'b11) || (in_op == 3'b110);
        in_misal = ((in_op[1:0] == 2'b01) && in_off[0]) ||
                   ((in_op[1:0] == 2'b10) && (in_off != 2'b00));
    end

    assign wd_expired   = WD_EN && (wd_cnt == WD_LAST);
    assign lane_single  = dmem_rdata_i >> {off, 3'b000};
    assign req_ready_o  = (state == S_IDLE);
    assign resp_valid_o = (state == S_DONE);
    assign dmem_req_o   = (state == S_ADDR) || (state == S_ADDR2);
    assign stall_o      = ((state != S_IDLE) && (state != S_DONE)) || ((state == S_IDLE) && req_valid_i);

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [2:0]  in_back;
    logic [2:0]  back;
    logic        split;
    logic [3:0]  be2;
    logic [31:0] wdata2;
    logic [31:0] beat1_data;
    logic [31:0] lane_merged;

    assign in_back = 3'd4 - {1'b0, in_off};
    assign back    = 3'd4 - {1'b0, off};
    // Beat 1 supplies bytes off..3, beat 2 supplies the bytes that spilled into the next word.
    assign lane_merged = (beat1_data >> {off, 3'b000}) | (dmem_rdata_i << {back, 3'b000});
`endif

    function automatic logic [31:0] extend(input logic [2:0] o, input logic [31:0] w);
        case (o)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            wd_cnt       <= '0;
            is_store     <= 1'b0;
            op           <= 3'd0;
            off          <= 2'd0;
            rd           <= 5'd0;
            resp_rdata_o <= 32'd0;
            resp_rd_o    <= 5'd0;
            resp_err_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'd0;
            dmem_addr_o  <= 32'd0;
            dmem_wdata_o <= 32'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split        <= 1'b0;
            be2          <= 4'd0;
            wdata2       <= 32'd0;
            beat1_data   <= 32'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        is_store <= req_store_i;
                        op       <= in_op;
                        off      <= in_off;
                        rd       <= req_rd_i;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        if (in_illegal) begin
`else
                        if (in_illegal || in_misal) begin
`endif
                            state        <= S_DONE;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'd0;
                            resp_rd_o    <= req_store_i ? 5'd0 : req_rd_i;
                        end else begin
                            state        <= S_ADDR;
                            wd_cnt       <= '0;
                            dmem_we_o    <= req_store_i;
                            dmem_be_o    <= in_mask << in_off;
                            dmem_addr_o  <= {req_addr_i[31:2], 2'b00};
                            dmem_wdata_o <= req_wdata_i << {in_off, 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
                            // A misaligned halfword that stays inside the word needs only one beat.
                            split  <= in_misal && ((in_mask >> in_back) != 4'd0);
                            be2    <= in_mask >> in_back;
                            wdata2 <= req_wdata_i >> {in_back, 3'b000};
`endif
                        end
                    end
                end
                S_ADDR, S_ADDR2: begin
                    if (dmem_gnt_i) begin
                        state  <= (state == S_ADDR) ? S_DATA : S_DATA2;
                        wd_cnt <= '0;
                    end else if (wd_expired) begin
                        state        <= S_DONE;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= 32'd0;
                        resp_rd_o    <= is_store ? 5'd0 : rd;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_DATA, S_DATA2: begin
                    if (dmem_rvalid_i) begin
                        resp_rd_o <= is_store ? 5'd0 : rd;
                        if (dmem_err_i) begin
                            state        <= S_DONE;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        end else if (state == S_DATA && split) begin
                            state        <= S_ADDR2;
                            wd_cnt       <= '0;
                            beat1_data   <= dmem_rdata_i;
                            dmem_addr_o  <= dmem_addr_o + 32'd4;
                            dmem_be_o    <= be2;
                            dmem_wdata_o <= wdata2;
                        end else if (state == S_DATA2) begin
                            state        <= S_DONE;
                            resp_err_o   <= 1'b0;
                            resp_rdata_o <= is_store ? 32'd0 : extend(op, lane_merged);
`endif
                        end else begin
                            state        <= S_DONE;
                            resp_err_o   <= 1'b0;
                            resp_rdata_o <= is_store ? 32'd0 : extend(op, lane_single);
                        end
                    end else if (wd_expired) begin
                        state        <= S_DONE;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= 32'd0;
                        resp_rd_o    <= is_store ? 5'd0 : rd;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= 32'd0;
                    resp_rd_o    <= 5'd0;
                end
            endcase
        end
    end
endmodule
